// File: rtl/noc_router_pkg.sv
// Shared definitions for the 5-port mesh router: packet field layout, port indices and
// dimension-ordered route helpers.
package noc_router_pkg;

   localparam int unsigned VC_BIT   = 63;
   localparam int unsigned XDIR_BIT = 62;
   localparam int unsigned YDIR_BIT = 61;
   localparam int unsigned XHOP_MSB = 55;
   localparam int unsigned XHOP_LSB = 52;
   localparam int unsigned YHOP_MSB = 51;
   localparam int unsigned YHOP_LSB = 48;
   localparam int unsigned SRC_MSB  = 47;
   localparam int unsigned SRC_LSB  = 32;

   localparam int unsigned NUM_PORTS = 5;
   localparam int unsigned NUM_VCS   = 2;

   localparam logic [2:0] P_EW = 3'd0;
   localparam logic [2:0] P_WE = 3'd1;
   localparam logic [2:0] P_NS = 3'd2;
   localparam logic [2:0] P_SN = 3'd3;
   localparam logic [2:0] P_PE = 3'd4;

   typedef struct packed {
      logic        vc;
      logic        xdir;
      logic        ydir;
      logic [4:0]  rsvd;
      logic [3:0]  xhop;
      logic [3:0]  yhop;
      logic [15:0] src;
      logic [31:0] payload;
   } pkt_t;

   // X first, then Y, then eject locally.
   function automatic logic [2:0] route_port(logic [63:0] raw);
      if (raw[XHOP_MSB:XHOP_LSB] != 4'd0) begin
         return raw[XDIR_BIT] ? P_EW : P_WE;
      end else if (raw[YHOP_MSB:YHOP_LSB] != 4'd0) begin
         return raw[YDIR_BIT] ? P_NS : P_SN;
      end
      return P_PE;
   endfunction

   function automatic logic [63:0] route_update(logic [63:0] raw);
      pkt_t pk;
      pk = pkt_t'(raw);
      if (pk.xhop != 4'd0) begin
         pk.xhop = pk.xhop - 4'd1;
      end else if (pk.yhop != 4'd0) begin
         pk.yhop = pk.yhop - 4'd1;
      end
      return pk;
   endfunction

endpackage

// File: rtl/noc_vc_buffer.sv
// Small circular FIFO holding packets of one virtual channel on one router input.
module noc_vc_buffer #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DEPTH      = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [2**AW];
   logic [AW-1:0]         wr_q, rd_q;
   logic [CW-1:0]         cnt_q;
   logic                  push_ok, pop_ok;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign data_o  = mem_q[rd_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
         end
         unique case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/noc_router.sv
// 5-port XY mesh router with two alternately-served VCs per input and per-output round-robin.
// Optional ROUTER_PKT_COUNT_EN adds a wrapping count of emitted packets on pkt_count.
module noc_router
   import noc_router_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 64,
   parameter logic [15:0] CURRENT_ADDRESS = 16'h0000,
   parameter int unsigned BUFFER_DEPTH    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  polarity,
`ifdef ROUTER_PKT_COUNT_EN
   output logic [15:0]           pkt_count,
`endif
   input  logic                  ewsi,
   input  logic [DATA_WIDTH-1:0] ewdi,
   output logic                  ewri,
   output logic                  ewso,
   output logic [DATA_WIDTH-1:0] ewdo,
   input  logic                  ewro,
   input  logic                  wesi,
   input  logic [DATA_WIDTH-1:0] wedi,
   output logic                  weri,
   output logic                  weso,
   output logic [DATA_WIDTH-1:0] wedo,
   input  logic                  wero,
   input  logic                  nssi,
   input  logic [DATA_WIDTH-1:0] nsdi,
   output logic                  nsri,
   output logic                  nsso,
   output logic [DATA_WIDTH-1:0] nsdo,
   input  logic                  nsro,
   input  logic                  snsi,
   input  logic [DATA_WIDTH-1:0] sndi,
   output logic                  snri,
   output logic                  snso,
   output logic [DATA_WIDTH-1:0] sndo,
   input  logic                  snro,
   input  logic                  pesi,
   input  logic [DATA_WIDTH-1:0] pedi,
   output logic                  peri,
   output logic                  peso,
   output logic [DATA_WIDTH-1:0] pedo,
   input  logic                  pero
);

   logic                  polarity_q;
   logic [NUM_PORTS-1:0]  in_valid, in_ready, out_ready;
   logic [DATA_WIDTH-1:0] in_data [NUM_PORTS];

   logic [NUM_VCS-1:0]    push  [NUM_PORTS];
   logic [NUM_VCS-1:0]    pop   [NUM_PORTS];
   logic [NUM_VCS-1:0]    full  [NUM_PORTS];
   logic [NUM_VCS-1:0]    empty [NUM_PORTS];
   logic [DATA_WIDTH-1:0] head  [NUM_PORTS][NUM_VCS];

   logic [NUM_PORTS-1:0]  req_valid;
   logic [2:0]            req_dst [NUM_PORTS];
   logic [DATA_WIDTH-1:0] req_pkt [NUM_PORTS];

   logic [NUM_PORTS-1:0]  win_valid;
   logic [2:0]            win_idx [NUM_PORTS];
   logic [NUM_PORTS-1:0]  granted_in;
   logic [2:0]            ptr_q [NUM_PORTS];
   logic [2:0]            ptr_d [NUM_PORTS];

   logic [NUM_PORTS-1:0]  so_q;
   logic [DATA_WIDTH-1:0] do_q [NUM_PORTS];

   assign in_valid  = {pesi, snsi, nssi, wesi, ewsi};
   assign out_ready = {pero, snro, nsro, wero, ewro};

   assign in_data[P_EW] = ewdi;
   assign in_data[P_WE] = wedi;
   assign in_data[P_NS] = nsdi;
   assign in_data[P_SN] = sndi;
   // Locally injected packets carry this node as their source.
   assign in_data[P_PE] = {pedi[DATA_WIDTH-1:SRC_MSB+1], CURRENT_ADDRESS, pedi[SRC_LSB-1:0]};

   assign polarity = polarity_q;

   assign ewri = in_ready[P_EW];
   assign weri = in_ready[P_WE];
   assign nsri = in_ready[P_NS];
   assign snri = in_ready[P_SN];
   assign peri = in_ready[P_PE];

   assign ewso = so_q[P_EW];
   assign weso = so_q[P_WE];
   assign nsso = so_q[P_NS];
   assign snso = so_q[P_SN];
   assign peso = so_q[P_PE];

   assign ewdo = do_q[P_EW];
   assign wedo = do_q[P_WE];
   assign nsdo = do_q[P_NS];
   assign sndo = do_q[P_SN];
   assign pedo = do_q[P_PE];

   // Inputs accept into VC ~polarity while VC polarity drains, so one buffer never sees both.
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign in_ready[p]  = ~full[p][~polarity_q];
      assign req_valid[p] = ~empty[p][polarity_q];
      assign req_pkt[p]   = head[p][polarity_q];
      assign req_dst[p]   = route_port(req_pkt[p]);

      for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
         assign push[p][v] = in_valid[p] & in_ready[p] & (in_data[p][VC_BIT] == 1'(v))
                             & (polarity_q != 1'(v));
         assign pop[p][v]  = granted_in[p] & (polarity_q == 1'(v));

         noc_vc_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (BUFFER_DEPTH)
         ) u_buf (
            .clk_i   (clk),
            .rst_i   (reset),
            .push_i  (push[p][v]),
            .data_i  (in_data[p]),
            .pop_i   (pop[p][v]),
            .data_o  (head[p][v]),
            .full_o  (full[p][v]),
            .empty_o (empty[p][v])
         );
      end
   end

   // Per-output round-robin search starting at the pointer; a grant needs downstream ready.
   always_comb begin
      int idx;
      idx = 0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         win_valid[o] = 1'b0;
         win_idx[o]   = '0;
         for (int off = 0; off < NUM_PORTS; off++) begin
            idx = int'(ptr_q[o]) + off;
            if (idx >= NUM_PORTS) begin
               idx = idx - NUM_PORTS;
            end
            if (!win_valid[o] && out_ready[o] && req_valid[idx] && (req_dst[idx] == 3'(o))) begin
               win_valid[o] = 1'b1;
               win_idx[o]   = 3'(idx);
            end
         end
      end
   end

   always_comb begin
      granted_in = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         ptr_d[o] = ptr_q[o];
         if (win_valid[o]) begin
            granted_in[win_idx[o]] = 1'b1;
            ptr_d[o] = (win_idx[o] == 3'(NUM_PORTS - 1)) ? 3'd0 : win_idx[o] + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         polarity_q <= 1'b0;
         so_q       <= '0;
         for (int o = 0; o < NUM_PORTS; o++) begin
            do_q[o]  <= '0;
            ptr_q[o] <= '0;
         end
      end else begin
         polarity_q <= ~polarity_q;
         so_q       <= win_valid;
         for (int o = 0; o < NUM_PORTS; o++) begin
            ptr_q[o] <= ptr_d[o];
            if (win_valid[o]) begin
               do_q[o] <= route_update(req_pkt[win_idx[o]]);
            end
         end
      end
   end

`ifdef ROUTER_PKT_COUNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 16'($countones(win_valid));
      end
   end

   assign pkt_count = cnt_q;
`endif

endmodule

// File: tb/tb_noc_router.sv
// Self-checking bench for noc_router: directed vector table, corner sequences and
// random traffic against a queue-based reference model.
module tb_noc_router;

   localparam logic [15:0] CA    = 16'h1234;
   localparam int          DEPTH = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  si = '0;
   logic [4:0]  ro = 5'h1f;
   logic [63:0] di [5];
   wire         polarity;
   wire  [4:0]  ri, so;
   wire  [63:0] dout [5];
`ifdef ROUTER_PKT_COUNT_EN
   wire  [15:0] pkt_count;
`endif

   always #5 clk = ~clk;

   noc_router #(.CURRENT_ADDRESS(CA)) dut (
      .clk(clk), .reset(reset), .polarity(polarity),
`ifdef ROUTER_PKT_COUNT_EN
      .pkt_count(pkt_count),
`endif
      .ewsi(si[0]), .ewdi(di[0]), .ewri(ri[0]), .ewso(so[0]), .ewdo(dout[0]), .ewro(ro[0]),
      .wesi(si[1]), .wedi(di[1]), .weri(ri[1]), .weso(so[1]), .wedo(dout[1]), .wero(ro[1]),
      .nssi(si[2]), .nsdi(di[2]), .nsri(ri[2]), .nsso(so[2]), .nsdo(dout[2]), .nsro(ro[2]),
      .snsi(si[3]), .sndi(di[3]), .snri(ri[3]), .snso(so[3]), .sndo(dout[3]), .snro(ro[3]),
      .pesi(si[4]), .pedi(di[4]), .peri(ri[4]), .peso(so[4]), .pedo(dout[4]), .pero(ro[4])
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: one queue per (port, vc), index port*2+vc; ports 0..4 = ew,we,ns,sn,pe.
   logic [63:0] mq [10][$];
   int          pol_m;
   int          ptr_m [5];
   logic [4:0]  so_m;
   logic [63:0] do_m [5];
   logic [15:0] cnt_m;

   function automatic int route_of(input logic [63:0] p);
      int xh, yh;
      xh = int'(p[55:52]);
      yh = int'(p[51:48]);
      if (xh != 0) return p[62] ? 0 : 1;
      if (yh != 0) return p[61] ? 2 : 3;
      return 4;
   endfunction

   function automatic logic [63:0] hop(input logic [63:0] p);
      logic [63:0] r;
      r = p;
      if (p[55:52] != 0)      r[55:52] = 4'(int'(p[55:52]) - 1);
      else if (p[51:48] != 0) r[51:48] = 4'(int'(p[51:48]) - 1);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 10; i++) mq[i].delete();
      pol_m = 0;
      so_m  = '0;
      cnt_m = '0;
      for (int o = 0; o < 5; o++) begin
         ptr_m[o] = 0;
         do_m[o]  = '0;
      end
   endtask

   // One clock: check ready, advance the model with the current inputs, then check outputs.
   task automatic cycle();
      logic [4:0]  ri_m, so_n;
      int          src [5];
      int          i, qi;
      logic [63:0] pk;
      so_n = '0;
      for (int p = 0; p < 5; p++) begin
         src[p]  = 0;
         ri_m[p] = (mq[p*2 + (1 - pol_m)].size() < DEPTH);
         check($sformatf("ri[%0d]", p), 64'(ri[p]), 64'(ri_m[p]));
      end
      for (int o = 0; o < 5; o++) begin
         for (int off = 0; off < 5; off++) begin
            i  = (ptr_m[o] + off) % 5;
            qi = i*2 + pol_m;
            if (!so_n[o] && ro[o] && mq[qi].size() > 0) begin
               if (route_of(mq[qi][0]) == o) begin
                  so_n[o] = 1'b1;
                  src[o]  = i;
               end
            end
         end
      end
      for (int o = 0; o < 5; o++) begin
         if (so_n[o]) begin
            qi      = src[o]*2 + pol_m;
            do_m[o] = hop(mq[qi][0]);
            void'(mq[qi].pop_front());
            ptr_m[o] = (src[o] + 1) % 5;
         end
      end
      for (int p = 0; p < 5; p++) begin
         pk = di[p];
         if (p == 4) pk[47:32] = CA;
         if (si[p] && ri_m[p] && (pk[63] == (pol_m == 0))) mq[p*2 + (1 - pol_m)].push_back(pk);
      end
      so_m  = so_n;
      cnt_m = cnt_m + 16'($countones(so_n));
      pol_m = 1 - pol_m;
      if (reset) model_reset();
      @(posedge clk);
      #1;
      check("polarity", 64'(polarity), 64'(pol_m));
      for (int o = 0; o < 5; o++) begin
         check($sformatf("so[%0d]", o), 64'(so[o]), 64'(so_m[o]));
         check($sformatf("do[%0d]", o), dout[o], do_m[o]);
      end
`ifdef ROUTER_PKT_COUNT_EN
      check("pkt_count", 64'(pkt_count), 64'(cnt_m));
`endif
   endtask

   // Advance until an input may accept a packet on the given VC.
   task automatic wait_phase(input logic vc);
      int guard;
      guard = 0;
      while ((pol_m == int'(vc)) && guard < 4) begin
         cycle();
         guard++;
      end
   endtask

   typedef struct {
      int          in_port;
      logic [63:0] pkt;
      int          out_port;
      logic [63:0] exp_pkt;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #400000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          seen, ri_low;
      logic [63:0] got [$];

      vecs[0] = '{4, 64'hC010_0000_1111_1111, 0, 64'hC000_1234_1111_1111};
      vecs[1] = '{1, 64'h0000_ABCD_DEAD_BEEF, 4, 64'h0000_ABCD_DEAD_BEEF};
      vecs[2] = '{0, 64'h2002_5555_0000_0001, 2, 64'h2001_5555_0000_0001};
      vecs[3] = '{3, 64'h8001_6666_0000_0002, 3, 64'h8000_6666_0000_0002};
      vecs[4] = '{2, 64'h8030_7777_1234_5678, 1, 64'h8020_7777_1234_5678};
      vecs[5] = '{4, 64'h1F11_9999_0000_00FF, 1, 64'h1F01_1234_0000_00FF};

      for (int p = 0; p < 5; p++) di[p] = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check("rst_polarity", 64'(polarity), 64'd0);
      check("rst_so", 64'(so), 64'd0);
      check("rst_ri", 64'(ri), 64'h1f);
      for (int o = 0; o < 5; o++) check($sformatf("rst_do[%0d]", o), dout[o], 64'd0);
      reset = 1'b0;

      // Idle: polarity alternates, nothing emitted.
      repeat (20) cycle();

      // Single packets, one per row, each emitted one cycle after acceptance.
      for (int k = 0; k < 6; k++) begin
         wait_phase(vecs[k].pkt[63]);
         si[vecs[k].in_port] = 1'b1;
         di[vecs[k].in_port] = vecs[k].pkt;
         cycle();
         si = '0;
         cycle();
         check($sformatf("vec%0d_so", k), 64'(so[vecs[k].out_port]), 64'd1);
         check($sformatf("vec%0d_do", k), dout[vecs[k].out_port], vecs[k].exp_pkt);
      end

      // Backpressure on east output.
      ro[0] = 1'b0;
      wait_phase(1'b1);
      si[4] = 1'b1;
      di[4] = 64'hC010_0000_1111_1111;
      cycle();
      si     = '0;
      seen   = 0;
      ri_low = 0;
      for (int c = 0; c < 10; c++) begin
         cycle();
         if (so[0]) seen++;
         if (pol_m == 0 && ri[4] == 1'b0) ri_low++;
      end
      check("bp_no_emit", 64'(seen), 64'd0);
      check("bp_peri_low", 64'(ri_low), 64'd5);
      ro[0] = 1'b1;
      seen  = 0;
      for (int c = 0; c < 2; c++) begin
         cycle();
         if (so[0] && dout[0] == 64'hC000_1234_1111_1111) seen++;
      end
      check("bp_release", 64'(seen), 64'd1);

      // Three inputs contend for the local output after a fresh reset.
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      wait_phase(1'b0);
      si    = 5'b01011;
      di[0] = 64'h0000_0000_0000_00A1;
      di[1] = 64'h0000_0000_0000_00A2;
      di[3] = 64'h0000_0000_0000_00A3;
      cycle();
      si = '0;
      for (int c = 0; c < 6; c++) begin
         cycle();
         if (so[4]) got.push_back(dout[4]);
      end
      check("cont_count", 64'(got.size()), 64'd3);
      if (got.size() == 3) begin
         check("cont_first", got[0], 64'h0000_0000_0000_00A1);
         check("cont_second", got[1], 64'h0000_0000_0000_00A2);
         check("cont_third", got[2], 64'h0000_0000_0000_00A3);
      end

      // Reset while a packet is blocked discards it.
      ro = '0;
      wait_phase(1'b1);
      si[4] = 1'b1;
      di[4] = 64'hC010_0000_2222_2222;
      cycle();
      si    = '0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      ro    = 5'h1f;
      seen  = 0;
      for (int c = 0; c < 4; c++) begin
         cycle();
         seen += $countones(so);
      end
      check("rst_discard", 64'(seen), 64'd0);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         si = 5'($urandom);
         ro = 5'($urandom) | 5'($urandom);
         for (int p = 0; p < 5; p++) begin
            di[p] = {$urandom, $urandom};
            di[p][55:52] = 4'($urandom_range(0, 2));
            di[p][51:48] = 4'($urandom_range(0, 2));
         end
         reset = ($urandom_range(0, 499) == 0);
         cycle();
      end
      si    = '0;
      ro    = 5'h1f;
      reset = 1'b0;
      repeat (6) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
